// File: rtl/ex_mul_div.sv
// Iterative 32-bit multiply/divide unit for the EX stage: shift-add multiply, restoring divide, HI/LO registers.
// Optional macro MULDIV_DIVIDE_EN compiles in DIV/DIVU; without it divide ops only pulse illegalOp.
module ex_mul_div (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] operandS,
    input  logic [31:0] operandT,
    input  logic        writeHi,
    input  logic        writeLo,
    input  logic [31:0] writeValue,
    output logic        busy,
    output logic        done,
    output logic        illegalOp,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [5:0]  count;
    logic [31:0] m_q;
    logic [63:0] acc, acc_step, result;
    logic        neg_q;
    logic        accept, last, op_ok;
    logic        s_neg, t_neg;
    logic [31:0] s_mag, t_mag;
    logic [32:0] add_sum;
`ifdef MULDIV_DIVIDE_EN
    logic        div_q, rem_neg_q;
    logic [32:0] rem_shift;
    logic [33:0] sub_diff;
`endif

    // NOTE: every signal written in an always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
`ifdef MULDIV_DIVIDE_EN
        op_ok = 1'b1;
`else
        op_ok = ~op[1];
`endif
        accept = start && (state != RUN) && op_ok;
        last   = (state == RUN) && (count == 6'd31);
        busy   = (state == RUN) || accept;
        done   = (state == DONE);
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    state_next = accept ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Signed ops (op[0]==0) run on magnitudes; the sign is restored when the result is written.
    always_comb begin
        s_neg = ~op[0] & operandS[31];
        t_neg = ~op[0] & operandT[31];
        s_mag = s_neg ? (32'd0 - operandS) : operandS;
        t_mag = t_neg ? (32'd0 - operandT) : operandT;
    end

    // acc holds {partial product, multiplier} for multiply and {remainder, quotient} for divide.
    always_comb begin
        add_sum  = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? m_q : 32'd0)};
        acc_step = {add_sum, acc[31:1]};
        result   = neg_q ? (64'd0 - acc_step) : acc_step;
`ifdef MULDIV_DIVIDE_EN
        rem_shift = acc[63:31];
        sub_diff  = {1'b0, rem_shift} - {2'b00, m_q};
        if (div_q) begin
            if (!sub_diff[33])
                acc_step = {sub_diff[31:0], acc[30:0], 1'b1};
            else
                acc_step = {rem_shift[31:0], acc[30:0], 1'b0};
            // A zero divisor leaves the dividend magnitude as remainder, so only the quotient needs forcing.
            result[31:0]  = (m_q == 32'd0) ? 32'hFFFF_FFFF
                          : (neg_q ? (32'd0 - acc_step[31:0]) : acc_step[31:0]);
            result[63:32] = rem_neg_q ? (32'd0 - acc_step[63:32]) : acc_step[63:32];
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            m_q   <= '0;
            acc   <= '0;
            neg_q <= 1'b0;
            hi    <= '0;
            lo    <= '0;
`ifdef MULDIV_DIVIDE_EN
            div_q     <= 1'b0;
            rem_neg_q <= 1'b0;
`endif
        end else begin
            state <= state_next;
            if (accept) begin
                count <= '0;
                neg_q <= s_neg ^ t_neg;
`ifdef MULDIV_DIVIDE_EN
                div_q     <= op[1];
                rem_neg_q <= s_neg;
                if (op[1]) begin
                    m_q <= t_mag;
                    acc <= {32'd0, s_mag};
                end else begin
                    m_q <= s_mag;
                    acc <= {32'd0, t_mag};
                end
`else
                m_q <= s_mag;
                acc <= {32'd0, t_mag};
`endif
            end else if (state == RUN) begin
                count <= count + 6'd1;
                acc   <= acc_step;
                if (last) begin
                    hi <= result[63:32];
                    lo <= result[31:0];
                end
            end else begin
                if (writeHi) hi <= writeValue;
                if (writeLo) lo <= writeValue;
            end
        end
    end

`ifdef MULDIV_DIVIDE_EN
    assign illegalOp = 1'b0;
`else
    always_ff @(posedge clock) begin
        if (reset) illegalOp <= 1'b0;
        else       illegalOp <= start && (state != RUN) && op[1];
    end
`endif

endmodule

// File: tb/tb_ex_mul_div.sv
// Self-checking bench for ex_mul_div: vector table, hand-written corner sequences and randomized ops vs. an arithmetic model.
// Divide checks are compiled only when MULDIV_DIVIDE_EN is defined, matching the design build.
module tb_ex_mul_div;

    logic        clock = 1'b0;
    logic        reset, start, writeHi, writeLo;
    logic [1:0]  op;
    logic [31:0] operandS, operandT, writeValue;
    logic        busy, done, illegalOp;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_fail   = 0;

    ex_mul_div dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .operandS(operandS), .operandT(operandT),
        .writeHi(writeHi), .writeLo(writeLo), .writeValue(writeValue),
        .busy(busy), .done(done), .illegalOp(illegalOp), .hi(hi), .lo(lo)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] s;
        logic [31:0] t;
        logic [63:0] expect_hilo;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Reference results from plain wide arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] s, input logic [31:0] t);
        logic signed [63:0] ss, st;
        longint q, r;
        ss = {{32{s[31]}}, s};
        st = {{32{t[31]}}, t};
        case (o)
            2'b00:   return ss * st;
            2'b01:   return {32'd0, s} * {32'd0, t};
            2'b10: begin
                if (t == 32'd0) return {s, 32'hFFFF_FFFF};
                q = longint'(ss) / longint'(st);
                r = longint'(ss) % longint'(st);
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (t == 32'd0) return {s, 32'hFFFF_FFFF};
                return {s % t, s / t};
            end
        endcase
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Issues one op in the current cycle (also valid in a DONE cycle) and follows it to completion.
    task automatic do_op(input logic [1:0] o, input logic [31:0] s, input logic [31:0] t,
                         input logic [63:0] exp, input string name);
        logic [63:0] prev;
        int cyc, busy_cnt, hold_bad;
        prev     = {hi, lo};
        start    = 1'b1;
        op       = o;
        operandS = s;
        operandT = t;
        #1;
        busy_cnt = busy ? 1 : 0;
        step();
        start    = 1'b0;
        #1;
        cyc      = 1;
        hold_bad = 0;
        while (!done && cyc < 100) begin
            busy_cnt += busy ? 1 : 0;
            if ({hi, lo} !== prev) hold_bad++;
            step();
            cyc++;
        end
        check($sformatf("%s latency", name), 64'(cyc), 64'd33);
        check($sformatf("%s busy cycles", name), 64'(busy_cnt), 64'd33);
        check($sformatf("%s hi/lo held while running", name), 64'(hold_bad), 64'd0);
        check($sformatf("%s result", name), {hi, lo}, exp);
        check($sformatf("%s illegalOp", name), 64'(illegalOp), 64'd0);
    endtask

    initial begin
        logic [63:0] saved;
        int cyc, pulses;
        logic [1:0]  ro;
        logic [31:0] rs, rt;

        vecs.push_back('{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001});
        vecs.push_back('{2'b00, 32'hFFFF_FFFD, 32'd7,         64'hFFFF_FFFF_FFFF_FFEB});
        vecs.push_back('{2'b00, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000});
        vecs.push_back('{2'b01, 32'd0,         32'h1234_5678, 64'h0000_0000_0000_0000});
        vecs.push_back('{2'b00, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0001});
`ifdef MULDIV_DIVIDE_EN
        vecs.push_back('{2'b10, 32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD});
        vecs.push_back('{2'b11, 32'd100,       32'd0,         64'h0000_0064_FFFF_FFFF});
        vecs.push_back('{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000});
        vecs.push_back('{2'b10, 32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD});
        vecs.push_back('{2'b10, 32'hFFFF_FFF9, 32'd0,         64'hFFFF_FFF9_FFFF_FFFF});
        vecs.push_back('{2'b11, 32'hFFFF_FFFF, 32'd16,        64'h0000_000F_0FFF_FFFF});
`endif

        // Reset held together with start and writes: reset must win.
        reset = 1'b1; start = 1'b1; op = 2'b01; operandS = 32'd3; operandT = 32'd5;
        writeHi = 1'b1; writeLo = 1'b1; writeValue = 32'hDEAD_BEEF;
        step();
        step();
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset illegalOp", 64'(illegalOp), 64'd0);
        reset = 1'b0; start = 1'b0; writeHi = 1'b0; writeLo = 1'b0;
        #1;
        check("busy after reset", 64'(busy), 64'd0);
        step();

        // Vector table; consecutive rows start in the previous row's DONE cycle.
        foreach (vecs[i])
            do_op(vecs[i].op, vecs[i].s, vecs[i].t, vecs[i].expect_hilo, $sformatf("vec%0d", i));

        // DONE without a new start falls back to IDLE.
        step();
        check("idle after done: done", 64'(done), 64'd0);
        check("idle after done: busy", 64'(busy), 64'd0);

        // MTHI / MTLO in IDLE.
        writeHi = 1'b1; writeValue = 32'h1234_5678;
        step();
        writeHi = 1'b0;
        check("mthi in idle", 64'(hi), 64'h1234_5678);
        writeLo = 1'b1; writeValue = 32'h0BAD_F00D;
        step();
        writeLo = 1'b0;
        check("mtlo in idle", 64'(lo), 64'h0BAD_F00D);

        // Write in the accepted start cycle and during RUN are both ignored.
        saved = {hi, lo};
        start = 1'b1; op = 2'b01; operandS = 32'd3; operandT = 32'd5;
        writeHi = 1'b1; writeValue = 32'hCAFE_F00D;
        step();
        start = 1'b0; writeHi = 1'b0;
        check("mthi with start ignored", 64'(hi), {32'd0, saved[63:32]});
        step();
        step();
        writeLo = 1'b1; writeValue = 32'hAAAA_5555;
        step();
        writeLo = 1'b0;
        check("mtlo during run ignored", 64'(lo), {32'd0, saved[31:0]});
        cyc = 4;
        while (!done && cyc < 100) begin
            step();
            cyc++;
        end
        check("start-with-write latency", 64'(cyc), 64'd33);
        check("start-with-write result", {hi, lo}, 64'd15);

        // Reset at iteration 10 aborts the op; no done pulse afterwards.
        step();
        start = 1'b1; op = 2'b01; operandS = 32'hFFFF_FFFF; operandT = 32'hFFFF_FFFF;
        step();
        start = 1'b0;
        for (int i = 0; i < 10; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check("abort hi", 64'(hi), 64'd0);
        check("abort lo", 64'(lo), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort busy", 64'(busy), 64'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done) pulses++;
        end
        check("abort no later done", 64'(pulses), 64'd0);

`ifndef MULDIV_DIVIDE_EN
        // Without the divider, DIV/DIVU never runs and only pulses illegalOp.
        writeHi = 1'b1; writeLo = 1'b1; writeValue = 32'h5A5A_A5A5;
        step();
        writeHi = 1'b0; writeLo = 1'b0;
        saved = {hi, lo};
        for (int k = 2; k < 4; k++) begin
            start = 1'b1; op = 2'(k); operandS = 32'd100; operandT = 32'd7;
            #1;
            check($sformatf("div op%0d busy", k), 64'(busy), 64'd0);
            step();
            start = 1'b0;
            #1;
            check($sformatf("div op%0d illegalOp pulse", k), 64'(illegalOp), 64'd1);
            check($sformatf("div op%0d busy after", k), 64'(busy), 64'd0);
            step();
            check($sformatf("div op%0d illegalOp cleared", k), 64'(illegalOp), 64'd0);
            check($sformatf("div op%0d no done", k), 64'(done), 64'd0);
            check($sformatf("div op%0d hi/lo unchanged", k), {hi, lo}, saved);
        end
`endif

        // Randomized ops against the arithmetic model, with random idle gaps.
        for (int n = 0; n < 40; n++) begin
`ifdef MULDIV_DIVIDE_EN
            ro = 2'($urandom_range(0, 3));
`else
            ro = 2'($urandom_range(0, 1));
`endif
            rs = rand_operand();
            rt = rand_operand();
            if ($urandom_range(0, 2) == 0) step();
            do_op(ro, rs, rt, model(ro, rs, rt), $sformatf("rand%0d op%0d %h,%h", n, ro, rs, rt));
        end

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_mul_div.md
EX_MUL_DIV -- requirements
Module: ex_mul_div

Interface
REQ-001 The block SHALL have one clock and a synchronous active-high reset, ports clock and reset.
REQ-002 Ports SHALL be:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- start  in  1  issue request from the EX stage, decoded from the ID/EX control word
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- operandS  in  32  rs value after forwarding
- operandT  in  32  rt value after forwarding
- writeHi  in  1  MTHI
- writeLo  in  1  MTLO
- writeValue  in  32  MTHI/MTLO data
- busy  out  1  stall request to the pipeline enables
- done  out  1  one-cycle completion pulse
- illegalOp  out  1  one-cycle pulse on an unsupported op
- hi  out  32  HI register
- lo  out  32  LO register

Function
REQ-003 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-004 When start=1 is sampled in IDLE or DONE, the FSM SHALL go to RUN, latch op and both operands, and clear the 6-bit iteration counter.
REQ-005 RUN SHALL perform exactly 32 iterations, one per cycle: shift-add for multiply, restoring for divide.
REQ-006 After the 32nd iteration the FSM SHALL go to DONE, and on that edge hi/lo SHALL load the result.
REQ-007 DONE SHALL last one cycle and then go to IDLE, unless start=1, which sends it to RUN.
REQ-008 Latency SHALL be 33 cycles from the start edge to done=1.
REQ-009 busy SHALL be combinational: 1 when (state==RUN) or (start=1 and state is IDLE or DONE); 0 otherwise.
REQ-010 done SHALL equal (state==DONE) and SHALL NOT depend on start.
REQ-011 start sampled during RUN SHALL be ignored.
REQ-012 MULT/MULTU: {hi,lo} SHALL be the 64-bit product, signed or unsigned.
REQ-013 Signed multiply SHALL be computed on magnitudes, with the sign fixed up at the end.
REQ-014 DIV/DIVU: lo SHALL be the quotient and hi the remainder.
REQ-015 Signed divide SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend.
REQ-016 A divisor of 0 SHALL give lo=32'hFFFF_FFFF and hi=the dividend, for both signed and unsigned ops.
REQ-017 DIV of 32'h8000_0000 by 32'hFFFF_FFFF SHALL give lo=32'h8000_0000 and hi=0.
REQ-018 writeHi/writeLo in IDLE or DONE SHALL load writeValue into hi/lo on the next edge.
REQ-019 writeHi/writeLo SHALL be ignored during RUN.
REQ-020 writeHi/writeLo SHALL be ignored in any cycle where start=1 is accepted.
REQ-021 illegalOp SHALL be 0 whenever the divider is compiled in.

Reset
REQ-022 When reset=1 at a rising edge, state SHALL become IDLE and the counter 0.
REQ-023 On that edge hi, lo, done and illegalOp SHALL be 0.
REQ-024 On that edge the internal operand and accumulator registers SHALL be 0.
REQ-025 Reset SHALL take priority over start and write inputs.
REQ-026 Reset during RUN SHALL abort the operation with no hi/lo update.
REQ-027 busy SHALL be 0 in the first cycle after reset unless start=1.

Configuration
REQ-028 Macro MULDIV_DIVIDE_EN defined: DIV/DIVU SHALL be implemented as specified above.
REQ-029 Macro MULDIV_DIVIDE_EN undefined: DIV/DIVU SHALL NOT enter RUN, SHALL NOT assert busy, and SHALL leave hi/lo unchanged.
REQ-030 Macro MULDIV_DIVIDE_EN undefined: illegalOp SHALL pulse for one cycle on the edge after a DIV/DIVU start is sampled.
REQ-031 Macro MULDIV_DIVIDE_EN undefined: multiply behaviour SHALL be identical to the defined case.

Verification
REQ-032 MULTU 32'hFFFF_FFFF x 32'hFFFF_FFFF -> done 33 cycles after start; hi=32'hFFFF_FFFE, lo=32'h0000_0001; busy=1 for 33 cycles, including the start cycle.
REQ-033 MULT 32'hFFFF_FFFD (-3) x 7 -> hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB.
REQ-034 DIV -7 / 2 -> lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF; DIVU 100 / 0 -> lo=32'hFFFF_FFFF, hi=100.
REQ-035 Back-to-back: start in the DONE cycle of op A -> op B done 33 cycles later; hi/lo hold A's result until then.
REQ-036 MTHI 32'h1234_5678 in IDLE -> hi=32'h1234_5678 the next cycle; MTLO during RUN -> lo unchanged.
REQ-037 Reset asserted at iteration 10 -> next cycle state IDLE, hi=lo=0, done=0; no done pulse ever follows.
